// File: rtl/temp_pkg.sv
// temp_pkg: types and constants shared by the temperature FIFO
// writer (clk_1 domain) and the averaging reader (clk_2 domain).
package temp_pkg;

  localparam int TEMP_DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVERT,
    S_SHIFT,
    S_WRITE,
    S_DONE
  } state_e;

endpackage

// File: rtl/sclk_gen.sv
// sclk_gen: ADC serial clock, low then high for SCLK_DIV/2 cycles
// each, for bits_i periods while en_i; pulses on rise and last high.
module sclk_gen #(
  parameter  int DATA_W   = 8,
  parameter  int SCLK_DIV = 4,
  localparam int BW       = $clog2(DATA_W + 1),
  localparam int DW       = $clog2(SCLK_DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic [BW-1:0] bits_i,
  output logic          sclk_o,
  output logic          rise_o,
  output logic          done_o
);

  localparam logic [DW-1:0] HALF = DW'(SCLK_DIV / 2);
  localparam logic [DW-1:0] LAST = DW'(SCLK_DIV - 1);
  localparam logic [BW-1:0] ONE  = BW'(1);

  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      bit_q <= '0;
    end else begin
      div_q <= div_d;
      bit_q <= bit_d;
    end
  end

  always_comb begin
    div_d = div_q;
    bit_d = bit_q;
    if (!en_i) begin
      div_d = '0;
      bit_d = '0;
    end else if (div_q == LAST) begin
      div_d = '0;
      bit_d = bit_q + ONE;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  assign sclk_o = en_i && (div_q >= HALF);
  assign rise_o = en_i && (div_q == HALF);
  assign done_o = en_i && (div_q == LAST)
                       && (bit_q == bits_i - ONE);

endmodule

// File: rtl/temp_sample_writer.sv
// temp_sample_writer: serial ADC burst reader feeding the temp FIFO.
// TEMP_WRITER_DROP_ON_FULL_EN: drop readings on full instead of stalling.
module temp_sample_writer
  import temp_pkg::*;
#(
  parameter int DATA_W      = TEMP_DATA_W,
  parameter int BURST       = 4,
  parameter int SCLK_DIV    = 4,
  parameter int CONV_CYCLES = 16
) (
  input  logic              clk_1,
  input  logic              reset_n,
  input  logic              start,
  input  logic              adc_sdo,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  input  logic              fifo_full,
  output logic              wr,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              burst_done,
  output logic [7:0]        drop_count
);

  localparam int CW = $clog2(CONV_CYCLES + 1);
  localparam int NW = $clog2(BURST + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] NBITS = BW'(DATA_W);

  state_e            state_q, state_d;
  logic [CW-1:0]     conv_q, conv_d;
  logic [NW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic              sclk_rise, sclk_done;
  logic              do_wr, do_drop;

  sclk_gen #(
    .DATA_W   (DATA_W),
    .SCLK_DIV (SCLK_DIV)
  ) u_sclk (
    .clk    (clk_1),
    .rst_n  (reset_n),
    .en_i   (state_q == S_SHIFT),
    .bits_i (NBITS),
    .sclk_o (adc_sclk),
    .rise_o (sclk_rise),
    .done_o (sclk_done)
  );

  always_ff @(posedge clk_1 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      conv_q  <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      conv_q  <= conv_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    conv_d  = conv_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    last_d  = last_q;
    do_wr   = 1'b0;
    do_drop = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CONVERT;
          conv_d  = '0;
          cnt_d   = '0;
        end
      end
      S_CONVERT: begin
        if (conv_q == CW'(CONV_CYCLES - 1)) begin
          state_d = S_SHIFT;
          conv_d  = '0;
        end else begin
          conv_d = conv_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (sclk_rise)
          shift_d = {shift_q[DATA_W-2:0], adc_sdo};
        if (sclk_done)
          state_d = S_WRITE;
      end
      S_WRITE: begin
        do_wr = !fifo_full;
`ifdef TEMP_WRITER_DROP_ON_FULL_EN
        do_drop = fifo_full;
`endif
        if (do_wr || do_drop) begin
          cnt_d  = cnt_q + 1'b1;
          conv_d = '0;
          if (do_wr)
            last_d = shift_q;
          if (cnt_q == NW'(BURST - 1))
            state_d = S_DONE;
          else
            state_d = S_CONVERT;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef TEMP_WRITER_DROP_ON_FULL_EN
  logic [7:0] drop_q;

  always_ff @(posedge clk_1 or negedge reset_n) begin
    if (!reset_n)
      drop_q <= '0;
    else if (do_drop && drop_q != 8'hFF)
      drop_q <= drop_q + 8'd1;
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

  // cs_n is high in WRITE so the ADC can start its next conversion
  assign adc_cs_n   = !(state_q == S_CONVERT || state_q == S_SHIFT);
  assign wr         = do_wr;
  assign data_out   = do_wr ? shift_q : last_q;
  assign busy       = (state_q != S_IDLE);
  assign burst_done = (state_q == S_DONE);

endmodule

// File: tb/tb_temp_sample_writer.sv
// Scoreboard bench for temp_sample_writer with a serial ADC model.
// Drop-on-full checks run only when TEMP_WRITER_DROP_ON_FULL_EN is set.
module tb_temp_sample_writer;

  logic       clk_1 = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       adc_sdo = 1'b0;
  logic       fifo_full = 1'b0;
  logic       adc_cs_n, adc_sclk, wr, busy, burst_done;
  logic [7:0] data_out, drop_count;

  temp_sample_writer dut (
    .clk_1      (clk_1),
    .reset_n    (reset_n),
    .start      (start),
    .adc_sdo    (adc_sdo),
    .adc_cs_n   (adc_cs_n),
    .adc_sclk   (adc_sclk),
    .fifo_full  (fifo_full),
    .wr         (wr),
    .data_out   (data_out),
    .busy       (busy),
    .burst_done (burst_done),
    .drop_count (drop_count)
  );

  always #5 clk_1 = ~clk_1;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk_1) cyc <= cyc + 1;

  logic [7:0] adc_q[$];
  logic [7:0] exp_q[$];
  int wr_t[$], bd_t[$], rise_t[$], fall_t[$], csf_t[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every write strobe
  logic sclk_p = 1'b0;
  logic cs_p = 1'b1;
  always @(negedge clk_1) begin
    if (wr) begin
      wr_t.push_back(cyc);
      chk("wr_vs_full", {31'd0, fifo_full}, 0);
      chk("cs_n_in_write", {31'd0, adc_cs_n}, 1);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_wr: got data %0h expected no write",
                 data_out);
      end else begin
        chk("data_out", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
      end
    end
    if (burst_done) bd_t.push_back(cyc);
    if (!sclk_p && adc_sclk) rise_t.push_back(cyc);
    if (sclk_p && !adc_sclk) fall_t.push_back(cyc);
    if (cs_p && !adc_cs_n) csf_t.push_back(cyc);
    sclk_p = adc_sclk;
    cs_p = adc_cs_n;
  end

  // ADC model: MSB out at cs_n fall, next bit after each sclk fall
  logic [7:0] cur = 8'h00;
  int bi = 0;
  logic ld = 1'b0;
  logic sclk_a = 1'b0;
  always @(negedge clk_1) begin
    if (adc_cs_n) begin
      ld = 1'b0;
      bi = 0;
    end else if (!ld) begin
      cur = (adc_q.size() != 0) ? adc_q.pop_front() : 8'h00;
      ld = 1'b1;
      bi = 0;
      adc_sdo = cur[7];
    end else if (sclk_a && !adc_sclk) begin
      bi++;
      if (bi < 8) adc_sdo = cur[7-bi];
    end
    sclk_a = adc_sclk;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_1);
    #1;
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic push(input logic [7:0] b);
    adc_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic clear_logs();
    wr_t.delete();
    bd_t.delete();
    rise_t.delete();
    fall_t.delete();
    csf_t.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_bd(input int target, input int budget);
    int b;
    b = 0;
    while (bd_t.size() < target && b < budget) begin
      tick(1);
      b++;
    end
    if (bd_t.size() < target) begin
      n_vec++;
      n_err++;
      $display("FAIL burst_done_timeout: got %0d expected %0d",
               bd_t.size(), target);
    end
  endtask

  int s;
  int bad;

  initial begin
    tick(3);
    chk("rst_cs_n", {31'd0, adc_cs_n}, 1);
    chk("rst_sclk", {31'd0, adc_sclk}, 0);
    chk("rst_wr", {31'd0, wr}, 0);
    chk("rst_data", {24'd0, data_out}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, burst_done}, 0);
    chk("rst_drop", {24'd0, drop_count}, 0);
    reset_n = 1'b1;
    tick(2);

    // plain burst, latency and sclk waveform
    clear_logs();
    push(8'hA5); push(8'h3C); push(8'hFF); push(8'h00);
    s = cyc;
    pulse_start();
    chk("t1_busy", {31'd0, busy}, 1);
    wait_bd(1, 400);
    tick(2);
    chk("t1_wr_count", wr_t.size(), 4);
    chk("t1_done_count", bd_t.size(), 1);
    chk("t1_busy_idle", {31'd0, busy}, 0);
    if (wr_t.size() == 4 && bd_t.size() == 1) begin
      chk("t1_first_lat", wr_t[0] - s, 49);
      for (int i = 1; i < 4; i++)
        chk("t1_spacing", wr_t[i] - wr_t[i-1], 49);
      chk("t1_done_after_last", bd_t[0] - wr_t[3], 1);
    end
    chk("t1_data_hold", {24'd0, data_out}, 0);
    chk("t5_cs_falls", csf_t.size(), 4);
    chk("t5_rise_count", rise_t.size(), 32);
    if (rise_t.size() >= 8 && fall_t.size() >= 8 && csf_t.size() >= 1) begin
      chk("t5_first_rise", rise_t[0] - csf_t[0], 18);
      bad = 0;
      for (int i = 1; i < 8; i++)
        if (rise_t[i] - rise_t[i-1] != 4) bad++;
      chk("t5_period", bad, 0);
      bad = 0;
      for (int i = 0; i < 8; i++)
        if (fall_t[i] - rise_t[i] != 2) bad++;
      chk("t5_high_len", bad, 0);
    end

    // fifo full stall at the second write
    clear_logs();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    s = cyc;
    pulse_start();
    tick_to(s + 98);
    fifo_full = 1'b1;
    tick(5);
    chk("t2_wr_low", {31'd0, wr}, 0);
    chk("t2_hold_data", {24'd0, data_out}, 8'h11);
    tick_to(s + 108);
    fifo_full = 1'b0;
    wait_bd(1, 400);
    chk("t2_wr_count", wr_t.size(), 4);
    if (wr_t.size() == 4) begin
      chk("t2_stall_wr", wr_t[1] - s, 108);
      chk("t2_after_stall", wr_t[2] - wr_t[1], 49);
    end

    // start pulses while busy are ignored
    tick(2);
    clear_logs();
    push(8'hC3); push(8'h5A); push(8'h81); push(8'h7E);
    s = cyc;
    pulse_start();
    tick_to(s + 20);
    pulse_start();
    tick_to(s + 70);
    pulse_start();
    wait_bd(1, 400);
    tick(100);
    chk("t3_wr_count", wr_t.size(), 4);
    chk("t3_done_count", bd_t.size(), 1);
    chk("t3_busy", {31'd0, busy}, 0);

    // reset during bit 5 of the second reading
    clear_logs();
    push(8'h12); push(8'h34); push(8'h56); push(8'h78);
    s = cyc;
    pulse_start();
    tick_to(s + 84);
    chk("t4_sclk_pre", {31'd0, adc_sclk}, 1);
    reset_n = 1'b0;
    #1;
    chk("t4_cs_n", {31'd0, adc_cs_n}, 1);
    chk("t4_sclk", {31'd0, adc_sclk}, 0);
    chk("t4_wr", {31'd0, wr}, 0);
    chk("t4_busy", {31'd0, busy}, 0);
    tick(3);
    chk("t4_data", {24'd0, data_out}, 0);
    chk("t4_wr_before", wr_t.size(), 1);
    adc_q.delete();
    exp_q.delete();
    reset_n = 1'b1;
    tick(2);
    clear_logs();
    push(8'h9A); push(8'hBC); push(8'hDE); push(8'hF0);
    pulse_start();
    wait_bd(1, 400);
    chk("t4_wr_count", wr_t.size(), 4);
    chk("t4_exp_left", exp_q.size(), 0);

`ifdef TEMP_WRITER_DROP_ON_FULL_EN
    tick(2);
    clear_logs();
    fifo_full = 1'b1;
    pulse_start();
    wait_bd(1, 400);
    tick(1);
    chk("t6_no_wr", wr_t.size(), 0);
    chk("t6_drop4", {24'd0, drop_count}, 4);
    for (int b = 1; b < 70; b++) begin
      pulse_start();
      wait_bd(b + 1, 400);
    end
    tick(1);
    chk("t6_bursts", bd_t.size(), 70);
    chk("t6_drop_sat", {24'd0, drop_count}, 255);
    fifo_full = 1'b0;
`else
    chk("t6_drop_zero", {24'd0, drop_count}, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
